// File: rtl/ts_pkg.sv
// Shared definitions for the crossing loader: geometry constants, the
// launch-FSM state type and stub-memory address packing.
// Optional build macro used by the loader top: TS_LOADER_DROP_CNT_EN.
package ts_pkg;

    localparam int N_OUT_LAYERS = 3;
    localparam int CNT_W        = 5;
    localparam int STUB_W       = 36;
    localparam int LYR_W        = 2;
    localparam int N_LAYERS     = N_OUT_LAYERS + 1;
    localparam int MAX_STUBS    = (1 << CNT_W) - 1;
    localparam int ADR_W        = 1 + LYR_W + CNT_W;

    typedef enum logic [1:0] {
        L_IDLE      = 2'd0,
        L_START     = 2'd1,
        L_WAIT_BSY  = 2'd2,
        L_WAIT_DONE = 2'd3
    } launch_state_t;

    // Stub memory address layout: {bank, layer, index}
    function automatic logic [ADR_W-1:0] pack_adr(
        input logic             bank,
        input logic [LYR_W-1:0] lyr,
        input logic [CNT_W-1:0] idx
    );
        return {bank, lyr, idx};
    endfunction

    // Layer indices above the outermost layer carry no storage
    function automatic logic lyr_valid(input logic [LYR_W-1:0] lyr);
        return (int'(lyr) <= N_OUT_LAYERS);
    endfunction

endpackage

// File: rtl/ts_bank_counts.sv
// One bank of the ping-pong stub store: per-layer stub counters with
// saturation at MAX_STUBS, plus the bank's full flag.
module ts_bank_counts
    import ts_pkg::*;
(
    input  logic                           clk,
    input  logic                           res,
    input  logic                           i_stub,
    input  logic [LYR_W-1:0]               i_lyr,
    input  logic                           i_seal,
    input  logic                           i_clear,
    output logic                           o_full,
    output logic                           o_sat,
    output logic [CNT_W-1:0]               o_sel_cnt,
    output logic [N_LAYERS-1:0][CNT_W-1:0] o_cnt
);

    logic                           r_full;
    logic [N_LAYERS-1:0][CNT_W-1:0] r_cnt;
    logic                           w_lyr_ok;
    logic                           w_inc;

    // Look up the addressed layer's count and decide whether it can grow
    always_comb begin
        w_lyr_ok  = lyr_valid(i_lyr);
        o_sel_cnt = {CNT_W{1'b0}};
        for (int k = 0; k < N_LAYERS; k++) begin
            o_sel_cnt = (i_lyr == LYR_W'(k)) ? r_cnt[k] : o_sel_cnt;
        end
        o_sat = w_lyr_ok && (o_sel_cnt == CNT_W'(MAX_STUBS));
        w_inc = i_stub && w_lyr_ok && !o_sat;
    end

    // Counters and full flag; a clear returns the bank to empty
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_full <= 1'b0;
            r_cnt  <= {(N_LAYERS*CNT_W){1'b0}};
        end else if (i_clear) begin
            r_full <= 1'b0;
            r_cnt  <= {(N_LAYERS*CNT_W){1'b0}};
        end else begin
            if (i_seal) begin
                r_full <= 1'b1;
            end
            for (int k = 0; k < N_LAYERS; k++) begin
                if (w_inc && (i_lyr == LYR_W'(k))) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign o_full = r_full;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/ts_crossing_loader.sv
// Crossing loader: fills a two-bank stub memory one crossing at a time,
// launches the crossing processor on each sealed bank in arrival order and
// frees the bank once the processor drops busy.
// Build macro TS_LOADER_DROP_CNT_EN adds the saturating drop_cnt output.
module ts_crossing_loader
    import ts_pkg::*;
(
    input  logic                        clk,
    input  logic                        res,
    input  logic                        stub_vld,
    input  logic [LYR_W-1:0]            stub_lyr,
    input  logic [STUB_W-1:0]           stub_dat,
    input  logic                        xing_end,
    output logic                        stub_rdy,
    output logic                        stub_mem_we,
    output logic [ADR_W-1:0]            stub_mem_adr,
    output logic [STUB_W-1:0]           stub_mem_dat,
    output logic                        proc_bank,
    output logic [CNT_W-1:0]            in_stub_cnt,
    output logic [N_OUT_LAYERS*CNT_W-1:0] out_stub_cnt,
    output logic                        start_cross_proc_sm,
    input  logic                        cross_proc_sm_bsy,
`ifdef TS_LOADER_DROP_CNT_EN
    output logic [15:0]                 drop_cnt,
`endif
    output logic                        stub_ovf
);

    logic                           r_fill_bank;
    logic                           r_proc_bank;
    logic                           r_stub_rdy;
    logic                           r_start;
    logic                           r_we;
    logic                           r_ovf;
    logic [ADR_W-1:0]               r_adr;
    logic [STUB_W-1:0]              r_dat;
    launch_state_t                  r_state;

    logic [1:0]                     w_full;
    logic [1:0]                     w_sat;
    logic [1:0]                     w_stub_b;
    logic [1:0]                     w_seal_b;
    logic [1:0]                     w_clear_b;
    logic [1:0]                     w_full_nxt;
    logic [CNT_W-1:0]               w_sel_cnt [2];
    logic [N_LAYERS-1:0][CNT_W-1:0] w_cnt [2];
    logic                           w_acc_stub;
    logic                           w_acc_end;
    logic                           w_lyr_ok;
    logic                           w_fill_sat;
    logic [CNT_W-1:0]               w_fill_idx;
    logic                           w_wr;
    logic                           w_ovf;
    logic                           w_free;
    logic                           w_fill_nxt;
    logic                           w_rdy_nxt;
    logic                           w_proc_full;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            ts_bank_counts u_bank (
                .clk       (clk),
                .res       (res),
                .i_stub    (w_stub_b[b]),
                .i_lyr     (stub_lyr),
                .i_seal    (w_seal_b[b]),
                .i_clear   (w_clear_b[b]),
                .o_full    (w_full[b]),
                .o_sat     (w_sat[b]),
                .o_sel_cnt (w_sel_cnt[b]),
                .o_cnt     (w_cnt[b])
            );
        end
    endgenerate

    // Handshake, routing of stub/seal/free events to banks, next readiness
    always_comb begin
        w_acc_stub  = r_stub_rdy && stub_vld;
        w_acc_end   = r_stub_rdy && xing_end;
        w_lyr_ok    = lyr_valid(stub_lyr);
        w_fill_sat  = r_fill_bank ? w_sat[1] : w_sat[0];
        w_fill_idx  = r_fill_bank ? w_sel_cnt[1] : w_sel_cnt[0];
        w_wr        = w_acc_stub && w_lyr_ok && !w_fill_sat;
        w_ovf       = w_acc_stub && w_lyr_ok && w_fill_sat;
        w_free      = (r_state == L_WAIT_DONE) && !cross_proc_sm_bsy;
        w_proc_full = r_proc_bank ? w_full[1] : w_full[0];
        w_stub_b    = {w_acc_stub && r_fill_bank, w_acc_stub && !r_fill_bank};
        w_seal_b    = {w_acc_end && r_fill_bank, w_acc_end && !r_fill_bank};
        w_clear_b   = {w_free && r_proc_bank, w_free && !r_proc_bank};
        // Seal and free always address different banks, so both apply
        w_full_nxt  = (w_full | w_seal_b) & ~w_clear_b;
        w_fill_nxt  = r_fill_bank ^ w_acc_end;
        w_rdy_nxt   = w_fill_nxt ? !w_full_nxt[1] : !w_full_nxt[0];
    end

    // Registered stub-memory write port, one write per stored stub
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_we  <= 1'b0;
            r_adr <= {ADR_W{1'b0}};
            r_dat <= {STUB_W{1'b0}};
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_adr <= pack_adr(r_fill_bank, stub_lyr, w_fill_idx);
                r_dat <= stub_dat;
            end
        end
    end

    // Fill-side state: bank pointer, registered ready, sticky overflow
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_fill_bank <= 1'b0;
            r_stub_rdy  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_fill_bank <= w_fill_nxt;
            r_stub_rdy  <= w_rdy_nxt;
            r_ovf       <= r_ovf | w_ovf;
        end
    end

    // Launch FSM: start pulse on a full bank, free it when busy drops
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= L_IDLE;
            r_start     <= 1'b0;
            r_proc_bank <= 1'b0;
        end else begin
            case (r_state)
                L_IDLE: begin
                    if (w_proc_full && !cross_proc_sm_bsy) begin
                        r_state <= L_START;
                        r_start <= 1'b1;
                    end
                end
                L_START: begin
                    r_start <= 1'b0;
                    r_state <= L_WAIT_BSY;
                end
                L_WAIT_BSY: begin
                    if (cross_proc_sm_bsy) begin
                        r_state <= L_WAIT_DONE;
                    end
                end
                L_WAIT_DONE: begin
                    if (!cross_proc_sm_bsy) begin
                        r_proc_bank <= ~r_proc_bank;
                        r_state     <= L_IDLE;
                    end
                end
                default: begin
                    r_state <= L_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    // Counts presented to the processor come from the bank it reads
    always_comb begin
        if (r_proc_bank) begin
            in_stub_cnt  = w_cnt[1][0];
            out_stub_cnt = w_cnt[1][N_LAYERS-1:1];
        end else begin
            in_stub_cnt  = w_cnt[0][0];
            out_stub_cnt = w_cnt[0][N_LAYERS-1:1];
        end
    end

`ifdef TS_LOADER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_acc_stub && !w_wr;

    // Saturating tally of stubs dropped for a full or invalid layer
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign stub_rdy            = r_stub_rdy;
    assign stub_mem_we         = r_we;
    assign stub_mem_adr        = r_adr;
    assign stub_mem_dat        = r_dat;
    assign proc_bank           = r_proc_bank;
    assign start_cross_proc_sm = r_start;
    assign stub_ovf            = r_ovf;

endmodule

// File: tb/tb_ts_crossing_loader.sv
// Scoreboard bench for ts_crossing_loader: expected memory writes and
// launches are queued with the stimulus and checked by a monitor process.
module tb_ts_crossing_loader;

    logic        clk = 1'b0;
    logic        res;
    logic        stub_vld;
    logic [1:0]  stub_lyr;
    logic [35:0] stub_dat;
    logic        xing_end;
    logic        stub_rdy;
    logic        stub_mem_we;
    logic [7:0]  stub_mem_adr;
    logic [35:0] stub_mem_dat;
    logic        proc_bank;
    logic [4:0]  in_stub_cnt;
    logic [14:0] out_stub_cnt;
    logic        start_cross_proc_sm;
    logic        cross_proc_sm_bsy;
    logic        stub_ovf;
`ifdef TS_LOADER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int pend  = 0;
    int bcnt  = 0;
    int busy_len = 20;

    logic [43:0] wq[$];   // {adr, dat}
    logic [20:0] lq[$];   // {bank, in_cnt, out_cnt}

    always #5 clk = ~clk;

    ts_crossing_loader dut (
        .clk                 (clk),
        .res                 (res),
        .stub_vld            (stub_vld),
        .stub_lyr            (stub_lyr),
        .stub_dat            (stub_dat),
        .xing_end            (xing_end),
        .stub_rdy            (stub_rdy),
        .stub_mem_we         (stub_mem_we),
        .stub_mem_adr        (stub_mem_adr),
        .stub_mem_dat        (stub_mem_dat),
        .proc_bank           (proc_bank),
        .in_stub_cnt         (in_stub_cnt),
        .out_stub_cnt        (out_stub_cnt),
        .start_cross_proc_sm (start_cross_proc_sm),
        .cross_proc_sm_bsy   (cross_proc_sm_bsy),
`ifdef TS_LOADER_DROP_CNT_EN
        .drop_cnt            (drop_cnt),
`endif
        .stub_ovf            (stub_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Processor model: busy rises the cycle after start, lasts busy_len cycles
    task automatic proc_model();
        forever begin
            @(posedge clk);
            #1;
            if (!res) begin
                cross_proc_sm_bsy = 1'b0;
                pend = 0;
                bcnt = 0;
            end else begin
                if (pend != 0) begin
                    cross_proc_sm_bsy = 1'b1;
                    bcnt = busy_len;
                    pend = 0;
                end else if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) cross_proc_sm_bsy = 1'b0;
                end
                if (start_cross_proc_sm) pend = 1;
            end
        end
    endtask

    // Monitor: pops the scoreboard on each write strobe and start pulse
    task automatic monitor();
        logic [43:0] ew;
        logic [20:0] el;
        forever begin
            @(negedge clk);
            if (res === 1'b1 && stub_mem_we === 1'b1) begin
                if (wq.size() == 0) chk("unexpected_write", {56'd0, stub_mem_adr}, 64'hDEAD);
                else begin
                    ew = wq.pop_front();
                    chk("mem_write", {20'd0, stub_mem_adr, stub_mem_dat}, {20'd0, ew});
                end
            end
            if (res === 1'b1 && start_cross_proc_sm === 1'b1) begin
                if (lq.size() == 0) chk("unexpected_start", {63'd0, proc_bank}, 64'hDEAD);
                else begin
                    el = lq.pop_front();
                    chk("launch", {43'd0, proc_bank, in_stub_cnt, out_stub_cnt}, {43'd0, el});
                end
            end
        end
    endtask

    // One handshake: present inputs, wait for ready, transfer on next edge
    task automatic xfer(input logic v, input logic [1:0] l, input logic [35:0] d, input logic e);
        int g;
        g = 0;
        @(negedge clk);
        stub_vld = v; stub_lyr = l; stub_dat = d; xing_end = e;
        while (stub_rdy !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("xfer_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        stub_vld = 1'b0; xing_end = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(lq.size() == 0 && wq.size() == 0 && cross_proc_sm_bsy == 1'b0 && pend == 0 && bcnt == 0)
               && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("idle_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int g;
        res = 1'b0; stub_vld = 1'b0; stub_lyr = 2'd0; stub_dat = 36'd0; xing_end = 1'b0;
        cross_proc_sm_bsy = 1'b0;
        fork
            proc_model();
            monitor();
        join_none

        // Reset state
        #12;
        chk("rst_rdy", {63'd0, stub_rdy}, 64'd0);
        chk("rst_we", {63'd0, stub_mem_we}, 64'd0);
        chk("rst_start", {63'd0, start_cross_proc_sm}, 64'd0);
        chk("rst_cnts", {44'd0, proc_bank, in_stub_cnt, out_stub_cnt}, 64'd0);
        chk("rst_ovf", {63'd0, stub_ovf}, 64'd0);
`ifdef TS_LOADER_DROP_CNT_EN
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
`endif
        @(negedge clk); res = 1'b1;
        repeat (2) @(negedge clk);
        chk("rdy_after_rst", {63'd0, stub_rdy}, 64'd1);

        // Crossing 1 into bank 0: two inner + one L1 stub (L1 rides xing_end)
        wq.push_back({8'h00, 36'h1_0000_00A1});
        wq.push_back({8'h01, 36'h2_0000_00A2});
        wq.push_back({8'h20, 36'h3_0000_00A3});
        lq.push_back({1'b0, 5'd2, 15'h0001});
        xfer(1'b1, 2'd0, 36'h1_0000_00A1, 1'b0);
        xfer(1'b1, 2'd0, 36'h2_0000_00A2, 1'b0);
        xfer(1'b1, 2'd1, 36'h3_0000_00A3, 1'b1);

        // Crossing 2 into bank 1 while the processor is busy: L2, L3, bare end
        wq.push_back({8'hC0, 36'h4_0000_00B1});
        wq.push_back({8'hE0, 36'h5_0000_00B2});
        lq.push_back({1'b1, 5'd0, 15'h0420});
        xfer(1'b1, 2'd2, 36'h4_0000_00B1, 1'b0);
        xfer(1'b1, 2'd3, 36'h5_0000_00B2, 1'b0);
        @(negedge clk);
        chk("no_stall_fill", {63'd0, stub_rdy}, 64'd1);
        xfer(1'b0, 2'd0, 36'd0, 1'b1);
        @(negedge clk);
        chk("stall_both_full", {63'd0, stub_rdy}, 64'd0);

        // Busy falls: ready rises next cycle, second start two cycles after
        g = 0;
        while (cross_proc_sm_bsy !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        while (cross_proc_sm_bsy === 1'b1 && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) chk("busy_timeout", 64'd0, 64'd1);
        chk("stall_until_free", {63'd0, stub_rdy}, 64'd0);
        @(negedge clk);
        chk("rdy_after_free", {63'd0, stub_rdy}, 64'd1);
        @(negedge clk);
        chk("start2_timing", {63'd0, start_cross_proc_sm}, 64'd1);
        chk("start2_bank", {63'd0, proc_bank}, 64'd1);

        // Crossing 3 into bank 0: stub with xing_end in the same cycle
        wq.push_back({8'h00, 36'h6_0000_00C1});
        lq.push_back({1'b0, 5'd1, 15'h0000});
        xfer(1'b1, 2'd0, 36'h6_0000_00C1, 1'b1);
        wait_idle();

        // 32 inner stubs into bank 1: 31 stored, last one overflows
        busy_len = 3;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("ovf_before_full", {63'd0, stub_ovf}, 64'd0);
            if (i < 31) wq.push_back({8'h80 | 8'(i), 36'h7_0000_0000 + 36'(i)});
            xfer(1'b1, 2'd0, 36'h7_0000_0000 + 36'(i), 1'b0);
        end
        chk("ovf_set", {63'd0, stub_ovf}, 64'd1);
`ifdef TS_LOADER_DROP_CNT_EN
        chk("drop_cnt_one", {48'd0, drop_cnt}, 64'd1);
`endif
        lq.push_back({1'b1, 5'd31, 15'h0000});
        xfer(1'b0, 2'd0, 36'd0, 1'b1);
        wait_idle();

        // Empty crossing into bank 0 still launches with zero counts
        lq.push_back({1'b0, 5'd0, 15'h0000});
        xfer(1'b0, 2'd0, 36'd0, 1'b1);
        wait_idle();
        chk("ovf_sticky", {63'd0, stub_ovf}, 64'd1);

        // Reset while the processor works on bank 1
        busy_len = 20;
        wq.push_back({8'hC0, 36'h8_0000_00D1});
        lq.push_back({1'b1, 5'd0, 15'h0020});
        xfer(1'b1, 2'd2, 36'h8_0000_00D1, 1'b1);
        g = 0;
        while (cross_proc_sm_bsy !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) chk("busy6_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        chk("pre_rst_bank", {49'd0, proc_bank, out_stub_cnt}, {49'd0, 1'b1, 15'h0020});
        #2 res = 1'b0;
        #1;
        chk("async_rst_outs", {44'd0, proc_bank, in_stub_cnt, out_stub_cnt}, 64'd0);
        chk("async_rst_ctl", {60'd0, stub_rdy, stub_mem_we, start_cross_proc_sm, stub_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        chk("rdy_after_rst2", {63'd0, stub_rdy}, 64'd1);
`ifdef TS_LOADER_DROP_CNT_EN
        chk("drop_rst", {48'd0, drop_cnt}, 64'd0);
`endif
        wq.push_back({8'h20, 36'h9_0000_00E1});
        lq.push_back({1'b0, 5'd0, 15'h0001});
        xfer(1'b1, 2'd1, 36'h9_0000_00E1, 1'b1);
        wait_idle();

        chk("writes_drained", 64'(wq.size()), 64'd0);
        chk("launches_drained", 64'(lq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ts_crossing_loader.md
Name: ts_crossing_loader

Overview:
- Upstream stage of the crossing processor. Accepts the stub stream for each bunch crossing and writes the stubs into a ping-pong (two-bank) stub memory.
- Keeps per-layer stub counts for each bank.
- Launches the crossing processor on a full bank with a one-cycle start strobe, and frees that bank when the processor drops busy.
- Filling of one crossing therefore overlaps processing of the previous one.

Parameters:
- N_OUT_LAYERS, 3, number of outer layers (layer 0 is the inner layer).
- STUB_W, 36, stub data width.
- CNT_W, 5, per-layer count width; max stubs per layer per crossing MAX_STUBS = 2**CNT_W-1.
- LYR_W, 2, layer index width; must satisfy 2**LYR_W >= N_OUT_LAYERS+1.

Ports:
- clk  in  1  pipeline clock
- res  in  1  reset, asynchronous, active-low
- stub_vld  in  1  stub present on stub_dat/stub_lyr
- stub_lyr  in  LYR_W  layer of stub (0 = inner)
- stub_dat  in  STUB_W  stub payload
- xing_end  in  1  last cycle of current crossing (may coincide with stub_vld)
- stub_rdy  out  1  loader accepts stub_vld/xing_end this cycle
- stub_mem_we  out  1  stub memory write strobe
- stub_mem_adr  out  1+LYR_W+CNT_W  {bank, layer, index}
- stub_mem_dat  out  STUB_W  write data
- proc_bank  out  1  bank the processor reads
- in_stub_cnt  out  CNT_W  inner count of proc_bank
- out_stub_cnt  out  N_OUT_LAYERS*CNT_W  outer counts of proc_bank; layer k at bits [k*CNT_W +: CNT_W], k=0 is outer layer 1
- start_cross_proc_sm  out  1  one-cycle launch pulse
- cross_proc_sm_bsy  in  1  processor busy
- stub_ovf  out  1  sticky: a stub was dropped for a full layer

Behaviour:
- Reset (res=0, async): all outputs 0, both banks empty, all counts 0, fill_bank=0, proc_bank=0, launch FSM in L_IDLE.
- Accept condition: a transfer occurs when stub_rdy=1 and (stub_vld or xing_end). stub_rdy = !full[fill_bank].
- Stub write: on an accepted stub_vld with cnt[fill_bank][lyr] < MAX_STUBS:
  - registered write, one cycle latency: stub_mem_we=1 and adr={fill_bank, lyr, cnt} in the next cycle;
  - the count increments.
  - If the count equals MAX_STUBS, the stub is dropped, stub_ovf is set and the count holds.
  - stub_lyr > N_OUT_LAYERS: stub is dropped; stub_ovf is not set.
- Seal: on an accepted xing_end, full[fill_bank] is set and fill_bank toggles.
  - If stub_vld is asserted in the same cycle, that stub belongs to the sealed crossing.
  - An empty crossing (xing_end with no stubs) is still sealed and launched with all counts 0.
- Stall: when both banks are full, stub_rdy=0. Upstream holds its data; nothing is accepted.
- Launch FSM (states L_IDLE, L_START, L_WAIT_BSY, L_WAIT_DONE):
  - L_IDLE: if full[proc_bank] and !cross_proc_sm_bsy -> L_START.
  - L_START: start_cross_proc_sm=1 for exactly one cycle -> L_WAIT_BSY.
  - L_WAIT_BSY: wait for cross_proc_sm_bsy=1, then -> L_WAIT_DONE. The processor raises busy one cycle after start.
  - L_WAIT_DONE: wait for cross_proc_sm_bsy=0, then clear full[proc_bank] and its counts, toggle proc_bank, -> L_IDLE.
- in_stub_cnt and out_stub_cnt are driven from the proc_bank count registers and stay stable from L_START until the bank is freed.
- Simultaneous events: if the bank is freed in the same cycle a seal hits the other bank, both take effect; stub_rdy rises the next cycle.
- Ordering: crossings are launched strictly in arrival order (banks alternate).

Optional Feature:
- Macro: TS_LOADER_DROP_CNT_EN.
- Defined: adds output port drop_cnt [15:0]. It is a saturating count of stubs dropped for overflow or bad layer, cleared only by reset.
- Undefined: the port and the counter are absent. stub_ovf behaves identically in both cases.

Decomposition:
- Shared package ts_pkg holds: constants N_OUT_LAYERS, CNT_W, STUB_W, LYR_W; the launch-state enum; and the address-packing function {bank, layer, index}.
- One natural sub-module: ts_bank_counts. It holds one bank's per-layer counters, full flag and saturation logic, and is instantiated twice.

Test Plan:
- Reset, then 2 inner + 1 outer-L1 stub + xing_end -> writes at adr {0,0,0}, {0,0,1}, {0,1,0}; start pulses once; in_stub_cnt=2, out_stub_cnt L1=1.
- Processor model holds busy 20 cycles while crossing 2 fills bank 1 -> no stall; second start occurs 2 cycles after busy falls; proc_bank=1.
- Three crossings back-to-back with a busy processor -> stub_rdy=0 after the second xing_end; it rises the cycle after the first bank frees; no data lost.
- 32 inner stubs into one crossing (CNT_W=5) -> 31 written, stub_ovf=1, in_stub_cnt=31; drop_cnt=1 when the macro is defined.
- xing_end alone -> start issued with all counts 0; stub_vld with xing_end in the same cycle -> that stub counted in the sealed bank.
- res asserted during L_WAIT_DONE -> outputs 0 immediately; both banks empty; next crossing goes to bank 0.
